// File: rtl/mult_disp_pkg.sv
// Shared types and defaults for the multiplier display sequencer.
package mult_disp_pkg;

    typedef enum logic [2:0] {
        IDLE,
        MSTART,
        MWAIT,
        CSTART,
        CWAIT,
        DONE,
        ERR
    } state_t;

    localparam logic [15:0] BCD_ERR_DEFAULT      = 16'hFFFF;
    localparam int          MULT_TIMEOUT_DEFAULT = 64;
    localparam int          CONV_TIMEOUT_DEFAULT = 64;

    // Counter width able to reach the larger of the two stage timeouts minus one.
    function automatic int wd_width(input int t0, input int t1);
        int larger;
        larger = (t0 > t1) ? t0 : t1;
        return (larger < 2) ? 1 : $clog2(larger);
    endfunction

    localparam int WD_W = wd_width(MULT_TIMEOUT_DEFAULT, CONV_TIMEOUT_DEFAULT);

endpackage

// File: rtl/mult_disp_seq_watchdog.sv
// Stage watchdog: clearable up-counter with a terminal-count compare.
// One instance serves both wait states; the caller selects the terminal value.
module seq_watchdog #(
    parameter int WIDTH = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             enable,
    input  logic [WIDTH-1:0] term,
    output logic             expired
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    // Clear has priority so a new stage always starts counting from zero.
    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable) begin
            count_d = count_q + WIDTH'(1);
        end
    end

    // Count register, cleared by the active-low asynchronous reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired = (count_q == term);

endmodule

// File: rtl/mult_disp_seq.sv
// Sequencer: go edge -> multiplier -> BCD converter -> display register,
// with an explicit start/done handshake and a watchdog on each wait stage.
module mult_disp_seq
    import mult_disp_pkg::*;
#(
    parameter int          W            = 4,
    parameter int          MULT_TIMEOUT = MULT_TIMEOUT_DEFAULT,
    parameter int          CONV_TIMEOUT = CONV_TIMEOUT_DEFAULT,
    parameter logic [15:0] BCD_ERR      = BCD_ERR_DEFAULT
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           go,
    input  logic [W-1:0]   a_in,
    input  logic [W-1:0]   b_in,
    output logic           mult_start,
    output logic [W-1:0]   mult_a,
    output logic [W-1:0]   mult_b,
    input  logic           mult_done,
    input  logic [2*W-1:0] mult_p,
    output logic           conv_start,
    output logic [11:0]    conv_bin,
    input  logic           conv_done,
    input  logic [15:0]    conv_bcd,
    output logic [15:0]    disp_bcd,
    output logic           busy,
    output logic           done,
    output logic           err
);

    localparam int WDW = wd_width(MULT_TIMEOUT, CONV_TIMEOUT);

    state_t           state_q, state_d;
    logic             go_q, go_d;
    logic [W-1:0]     mult_a_q, mult_a_d;
    logic [W-1:0]     mult_b_q, mult_b_d;
    logic [2*W-1:0]   prod_q, prod_d;
    logic [15:0]      disp_q, disp_d;
    logic             err_q, err_d;

    logic             go_edge;
    logic             wd_clear;
    logic             wd_en;
    logic [WDW-1:0]   wd_term;
    logic             wd_expired;

    assign go_edge = go & ~go_q;

    seq_watchdog #(
        .WIDTH (WDW)
    ) u_watchdog (
        .clk     (clk),
        .rst     (rst),
        .clear   (wd_clear),
        .enable  (wd_en),
        .term    (wd_term),
        .expired (wd_expired)
    );

    // Next-state and datapath updates; a unit's done beats its own timeout.
    always_comb begin
        state_d  = state_q;
        go_d     = go;
        mult_a_d = mult_a_q;
        mult_b_d = mult_b_q;
        prod_d   = prod_q;
        disp_d   = disp_q;
        err_d    = err_q;
        wd_clear = 1'b0;
        wd_en    = 1'b0;
        wd_term  = WDW'(MULT_TIMEOUT - 1);
        case (state_q)
            IDLE, ERR: begin
                if (go_edge) begin
                    mult_a_d = a_in;
                    mult_b_d = b_in;
                    err_d    = 1'b0;
                    if (a_in == '0 || b_in == '0) begin
                        prod_d  = '0;
                        state_d = CSTART;
                    end else begin
                        state_d = MSTART;
                    end
                end
            end
            MSTART: begin
                wd_clear = 1'b1;
                state_d  = MWAIT;
            end
            MWAIT: begin
                if (mult_done) begin
                    prod_d  = mult_p;
                    state_d = CSTART;
                end else if (wd_expired) begin
                    disp_d  = BCD_ERR;
                    err_d   = 1'b1;
                    state_d = ERR;
                end else begin
                    wd_en = 1'b1;
                end
            end
            CSTART: begin
                wd_clear = 1'b1;
                state_d  = CWAIT;
            end
            CWAIT: begin
                wd_term = WDW'(CONV_TIMEOUT - 1);
                if (conv_done) begin
                    disp_d  = conv_bcd;
                    state_d = DONE;
                end else if (wd_expired) begin
                    disp_d  = BCD_ERR;
                    err_d   = 1'b1;
                    state_d = ERR;
                end else begin
                    wd_en = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers; go_q resets high so a held go cannot start a run.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            go_q     <= 1'b1;
            mult_a_q <= '0;
            mult_b_q <= '0;
            prod_q   <= '0;
            disp_q   <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            go_q     <= go_d;
            mult_a_q <= mult_a_d;
            mult_b_q <= mult_b_d;
            prod_q   <= prod_d;
            disp_q   <= disp_d;
            err_q    <= err_d;
        end
    end

    assign mult_start = (state_q == MSTART);
    assign conv_start = (state_q == CSTART);
    assign done       = (state_q == DONE);
    assign busy       = (state_q != IDLE) && (state_q != ERR);
    assign mult_a     = mult_a_q;
    assign mult_b     = mult_b_q;
    assign conv_bin   = 12'(prod_q);
    assign disp_bcd   = disp_q;
    assign err        = err_q;

endmodule

// File: tb/tb_mult_disp_seq.sv
// Scoreboard bench for mult_disp_seq with behavioural multiplier/converter responders.
module tb_mult_disp_seq;

    localparam int W = 4;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic           go = 1'b0;
    logic [W-1:0]   a_in = '0;
    logic [W-1:0]   b_in = '0;
    logic           mult_start;
    logic [W-1:0]   mult_a;
    logic [W-1:0]   mult_b;
    logic           mult_done = 1'b0;
    logic [2*W-1:0] mult_p = '0;
    logic           conv_start;
    logic [11:0]    conv_bin;
    logic           conv_done = 1'b0;
    logic [15:0]    conv_bcd = '0;
    logic [15:0]    disp_bcd;
    logic           busy;
    logic           done;
    logic           err;

    mult_disp_seq #(
        .W            (W),
        .MULT_TIMEOUT (64),
        .CONV_TIMEOUT (64),
        .BCD_ERR      (16'hFFFF)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .go         (go),
        .a_in       (a_in),
        .b_in       (b_in),
        .mult_start (mult_start),
        .mult_a     (mult_a),
        .mult_b     (mult_b),
        .mult_done  (mult_done),
        .mult_p     (mult_p),
        .conv_start (conv_start),
        .conv_bin   (conv_bin),
        .conv_done  (conv_done),
        .conv_bcd   (conv_bcd),
        .disp_bcd   (disp_bcd),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] disp;
        logic        err;
    } exp_t;

    exp_t           exp_q[$];
    exp_t           exp_e;
    int             checks = 0;
    int             failures = 0;

    bit             mult_respond = 1'b1;
    int             mult_lat = 8;
    int             conv_lat = 14;
    logic [2*W-1:0] cur_p = '0;
    logic [15:0]    cur_bcd = '0;

    int             ms_cnt = 0;
    int             cs_cnt = 0;
    int             done_cnt = 0;
    logic [W-1:0]   ma_seen = '0;
    logic [W-1:0]   mb_seen = '0;
    logic [11:0]    cb_seen = '0;
    logic           err_prev = 1'b0;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, actual, expected);
        end
    endtask

    // Issue one go pulse and queue the display word the run should produce.
    task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic [2*W-1:0] p, input logic [15:0] bcd,
                                 input bit push, input logic [15:0] exp_disp, input logic exp_err);
        exp_t e;
        a_in    = a;
        b_in    = b;
        cur_p   = p;
        cur_bcd = bcd;
        if (push) begin
            e.disp = exp_disp;
            e.err  = exp_err;
            exp_q.push_back(e);
        end
        go = 1'b1;
        @(negedge clk);
        go = 1'b0;
    endtask

    task automatic waitIdle(input string name);
        int n;
        n = 0;
        while (busy && n < 400) begin
            @(negedge clk);
            n++;
        end
        checkOutput({name, "_reaches_idle"}, 32'(busy), 32'd0);
    endtask

    // Multiplier model: answers a start pulse after mult_lat cycles.
    initial begin
        forever begin
            @(negedge clk);
            if (mult_start && mult_respond) begin
                repeat (mult_lat) @(negedge clk);
                mult_p    = cur_p;
                mult_done = 1'b1;
                @(negedge clk);
                mult_done = 1'b0;
            end
        end
    end

    // Converter model: answers a start pulse after conv_lat cycles.
    initial begin
        forever begin
            @(negedge clk);
            if (conv_start) begin
                repeat (conv_lat) @(negedge clk);
                conv_bcd  = cur_bcd;
                conv_done = 1'b1;
                @(negedge clk);
                conv_done = 1'b0;
            end
        end
    end

    // Monitor: counts handshakes and pops the scoreboard on done or err rising.
    always @(negedge clk) begin
        if (rst) begin
            if (mult_start) begin
                ms_cnt++;
                ma_seen = mult_a;
                mb_seen = mult_b;
            end
            if (conv_start) begin
                cs_cnt++;
                cb_seen = conv_bin;
            end
            if (done) done_cnt++;
            if (done || (err && !err_prev)) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("[TB] FAIL sb_unexpected_result actual=0x%0h required=no result", disp_bcd);
                end else begin
                    exp_e = exp_q.pop_front();
                    checkOutput("sb_disp_bcd", 32'(disp_bcd), 32'(exp_e.disp));
                    checkOutput("sb_err", 32'(err), 32'(exp_e.err));
                end
            end
            err_prev = err;
        end else begin
            err_prev = 1'b0;
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL global_timeout actual=running required=finished");
        $fatal(1, "[TB] simulation time limit reached");
    end

    initial begin
        int base_ms;
        int base_cs;
        int base_done;
        int n;

        // Reset with go held high, then release.
        rst = 1'b0;
        go  = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_done", 32'(done), 32'd0);
        checkOutput("rst_err", 32'(err), 32'd0);
        checkOutput("rst_mult_start", 32'(mult_start), 32'd0);
        checkOutput("rst_conv_start", 32'(conv_start), 32'd0);
        checkOutput("rst_disp_bcd", 32'(disp_bcd), 32'h0000);
        checkOutput("rst_conv_bin", 32'(conv_bin), 32'd0);
        checkOutput("rst_mult_ab", 32'({mult_a, mult_b}), 32'd0);
        repeat (20) @(negedge clk);
        checkOutput("held_go_no_start", 32'(ms_cnt), 32'd0);
        checkOutput("held_go_not_busy", 32'(busy), 32'd0);
        go = 1'b0;
        @(negedge clk);

        // 15 x 15 = 225
        $display("[TB] run 15x15");
        base_ms = ms_cnt; base_done = done_cnt;
        mult_lat = 8; conv_lat = 14;
        applyStimulus(4'd15, 4'd15, 8'd225, 16'h0225, 1'b1, 16'h0225, 1'b0);
        waitIdle("run_15x15");
        checkOutput("15x15_mult_start_count", 32'(ms_cnt - base_ms), 32'd1);
        checkOutput("15x15_mult_a", 32'(ma_seen), 32'd15);
        checkOutput("15x15_mult_b", 32'(mb_seen), 32'd15);
        checkOutput("15x15_conv_bin", 32'(cb_seen), 32'd225);
        checkOutput("15x15_done_cycles", 32'(done_cnt - base_done), 32'd1);
        checkOutput("15x15_disp_bcd", 32'(disp_bcd), 32'h0225);

        // Zero operand skips the multiplier.
        $display("[TB] run 0x9");
        base_ms = ms_cnt; base_cs = cs_cnt; base_done = done_cnt;
        applyStimulus(4'd0, 4'd9, 8'd99, 16'h0000, 1'b1, 16'h0000, 1'b0);
        waitIdle("run_0x9");
        checkOutput("0x9_no_mult_start", 32'(ms_cnt - base_ms), 32'd0);
        checkOutput("0x9_conv_start_count", 32'(cs_cnt - base_cs), 32'd1);
        checkOutput("0x9_conv_bin", 32'(cb_seen), 32'd0);
        checkOutput("0x9_done_cycles", 32'(done_cnt - base_done), 32'd1);

        // Multiplier never answers: error after 64 MWAIT cycles.
        $display("[TB] run multiplier timeout");
        mult_respond = 1'b0;
        applyStimulus(4'd6, 4'd7, 8'd42, 16'h0042, 1'b1, 16'hFFFF, 1'b1);
        checkOutput("timeout_mult_start_seen", 32'(mult_start), 32'd1);
        n = 0;
        while (!err && n < 200) begin
            @(negedge clk);
            n++;
        end
        checkOutput("timeout_latency", 32'(n), 32'd65);
        checkOutput("timeout_err", 32'(err), 32'd1);
        checkOutput("timeout_disp_bcd", 32'(disp_bcd), 32'hFFFF);
        checkOutput("timeout_busy", 32'(busy), 32'd0);
        mult_respond = 1'b1;
        repeat (3) @(negedge clk);

        // Recovery from ERR: 3 x 5 = 15.
        $display("[TB] run 3x5 after error");
        mult_lat = 6;
        applyStimulus(4'd3, 4'd5, 8'd15, 16'h0015, 1'b1, 16'h0015, 1'b0);
        checkOutput("recover_err_cleared", 32'(err), 32'd0);
        checkOutput("recover_busy", 32'(busy), 32'd1);
        checkOutput("recover_disp_held", 32'(disp_bcd), 32'hFFFF);
        waitIdle("run_3x5");
        checkOutput("3x5_disp_bcd", 32'(disp_bcd), 32'h0015);

        // Second go edge during MWAIT is dropped.
        $display("[TB] run 2x3 with extra go edge");
        base_ms = ms_cnt; base_done = done_cnt;
        mult_lat = 20;
        applyStimulus(4'd2, 4'd3, 8'd6, 16'h0006, 1'b1, 16'h0006, 1'b0);
        repeat (5) @(negedge clk);
        go = 1'b1;
        @(negedge clk);
        go = 1'b0;
        waitIdle("run_2x3");
        repeat (3) @(negedge clk);
        checkOutput("extra_edge_mult_start_count", 32'(ms_cnt - base_ms), 32'd1);
        checkOutput("extra_edge_done_count", 32'(done_cnt - base_done), 32'd1);

        // mult_done on the same cycle as the timeout wins.
        $display("[TB] run 4x4 with done at timeout");
        base_ms = ms_cnt;
        mult_lat = 64;
        applyStimulus(4'd4, 4'd4, 8'd16, 16'h0016, 1'b1, 16'h0016, 1'b0);
        waitIdle("run_4x4");
        checkOutput("coincident_err", 32'(err), 32'd0);
        checkOutput("coincident_disp_bcd", 32'(disp_bcd), 32'h0016);
        checkOutput("coincident_mult_start_count", 32'(ms_cnt - base_ms), 32'd1);

        // Reset asserted mid-CWAIT abandons the run.
        $display("[TB] run 9x9 aborted by reset");
        mult_lat = 3; conv_lat = 14;
        applyStimulus(4'd9, 4'd9, 8'd81, 16'h0081, 1'b0, 16'h0000, 1'b0);
        n = 0;
        while (!conv_start && n < 100) begin
            @(negedge clk);
            n++;
        end
        checkOutput("abort_conv_start_seen", 32'(conv_start), 32'd1);
        repeat (5) @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        checkOutput("abort_busy", 32'(busy), 32'd0);
        checkOutput("abort_disp_bcd", 32'(disp_bcd), 32'h0000);
        checkOutput("abort_conv_bin", 32'(conv_bin), 32'd0);
        checkOutput("abort_mult_ab", 32'({mult_a, mult_b}), 32'd0);
        checkOutput("abort_done_err", 32'({done, err}), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        base_done = done_cnt;
        repeat (20) @(negedge clk);
        checkOutput("abort_stray_conv_done_ignored", 32'(done_cnt - base_done), 32'd0);
        checkOutput("abort_disp_still_zero", 32'(disp_bcd), 32'h0000);

        // Fresh run after reset: 7 x 6 = 42.
        $display("[TB] run 7x6 after reset");
        mult_lat = 5;
        applyStimulus(4'd7, 4'd6, 8'd42, 16'h0042, 1'b1, 16'h0042, 1'b0);
        waitIdle("run_7x6");
        checkOutput("7x6_disp_bcd", 32'(disp_bcd), 32'h0042);

        repeat (3) @(negedge clk);
        checkOutput("sb_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mult_disp_seq.md
# mult_disp_seq

Sequencing controller for the multiplier display path. On a start request it captures the 4-bit operands and runs the sequential multiplier. It then runs the binary-to-BCD converter on the product and latches the result into the display register that feeds the digit mux / 7-segment path. It replaces free-running conversion with an explicit start/done handshake to each unit and adds a watchdog per stage.

## Interface
- W, 4: operand width; product is 2W bits, zero-extended to 12 bits for the converter
- MULT_TIMEOUT, 64: max cycles in MWAIT before error
- CONV_TIMEOUT, 64: max cycles in CWAIT before error
- BCD_ERR, 16'hFFFF: display word on error (renders blank)

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset
- go  in  1  start request, level; rising edge detected internally
- a_in, b_in  in  W  operands, sampled on accepted go
- mult_start  out  1  one-cycle start pulse to multiplier
- mult_a, mult_b  out  W  captured operands, stable from acceptance to return to IDLE
- mult_done  in  1  multiplier result valid, sampled only in MWAIT
- mult_p  in  2W  product
- conv_start  out  1  one-cycle start pulse to converter
- conv_bin  out  12  {4'b0, product}, stable from CSTART through CWAIT
- conv_done  in  1  BCD valid, sampled only in CWAIT
- conv_bcd  in  16  four BCD digits
- disp_bcd  out  16  registered display word
- busy  out  1  high in every state except IDLE and ERR
- done  out  1  one-cycle pulse after a successful display update
- err  out  1  sticky stage-timeout flag

## Operation
- go_q holds go delayed one cycle. An edge is go=1 with go_q=0. go_q resets to 1, so a go held high through reset release does not start a run.
- IDLE / ERR + edge: capture a_in/b_in into mult_a/mult_b; clear err.
  - If a_in==0 or b_in==0: prod_q<=0, go to CSTART. No multiplier run.
  - Otherwise go to MSTART.
- MSTART: mult_start=1; clear watchdog; go to MWAIT.
- MWAIT: on mult_done, prod_q<=mult_p, go to CSTART. Else, if watchdog==MULT_TIMEOUT-1, go to ERR. Else increment watchdog.
- CSTART: conv_start=1; clear watchdog; go to CWAIT.
- CWAIT: on conv_done, disp_bcd<=conv_bcd, go to DONE. Else, if watchdog==CONV_TIMEOUT-1, go to ERR.
- DONE: done=1 for one cycle; go to IDLE.
- ERR: on entry disp_bcd<=BCD_ERR and err<=1. Stays until the next accepted edge.
- Edges while busy are dropped, not queued.
- done/mult_done arriving in the same cycle as timeout: done wins.
- Stray mult_done/conv_done outside their wait states are ignored.
- disp_bcd changes only on CWAIT completion or ERR entry.

## Timing
- Reset, asynchronous, any state: state=IDLE; mult_start, conv_start, done, err, busy=0; mult_a, mult_b, conv_bin, disp_bcd, prod_q, watchdog=0; go_q=1. Any in-flight run is abandoned.
- Edge sampled at clock edge N: MSTART during cycle N..N+1, so mult_start is high for exactly one cycle.
- mult_done sampled at edge M: conv_start is high for the cycle after M.
- conv_done sampled at edge K: disp_bcd updates at K; done is high for cycle K..K+1; IDLE at K+1.
- Earliest next accepted go edge: the edge after IDLE is reached.
- Error latency: ERR entered exactly MULT_TIMEOUT (or CONV_TIMEOUT) cycles after entering the wait state.
- Overhead beyond unit latencies: 4 cycles (MSTART, CSTART, DONE, plus acceptance).

## Structure
- Package mult_disp_pkg holds:
  - state enum: IDLE, MSTART, MWAIT, CSTART, CWAIT, DONE, ERR
  - BCD_ERR default
  - watchdog width, $clog2 of the larger timeout
- One sub-module, seq_watchdog: clear/enable/terminal-count compare, instantiated once and shared by both wait states.
- FSM, edge detect and output registers live in mult_disp_seq.

## Test plan
- Reset with go held high, then release: all outputs 0, disp_bcd=16'h0000; no mult_start for 20 cycles until go drops and rises again.
- a=15, b=15, go pulse; model mult_done after 8 cycles with p=225 and conv_done after 14 cycles with bcd=16'h0225:
  - exactly one mult_start with mult_a=mult_b=15
  - conv_bin=12'd225
  - disp_bcd=16'h0225, done high for one cycle
- a=0, b=9: no mult_start; conv_bin=0; disp_bcd=16'h0000; done pulses.
- Multiplier never responds:
  - err=1 and disp_bcd=16'hFFFF exactly 64 cycles after MWAIT entry; busy=0
  - then a=3, b=5, go: err clears at acceptance; disp_bcd=16'h0015
- Robustness, second edge and simultaneous events:
  - Second go edge during MWAIT is ignored: only one mult_start.
  - mult_done coincident with the 64th MWAIT cycle proceeds to CSTART, err stays 0.
- rst pulsed low mid-CWAIT: outputs return to reset values immediately. A following a=7, b=6 run yields disp_bcd=16'h0042.
